// File: rtl/alu_pkg.sv
// Shared ALU definitions: Y86-64 OPq function codes and the checker FSM state encoding.
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_XOR = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_response_checker_if.sv
// Vector handshake between the ALU under test (master) and the response checker (slave).
interface alu_response_checker_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alu_fun;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] out;
  logic             zf;
  logic             sf;
  logic             of;

  modport master (
    output in_valid, alu_fun, a, b, out, zf, sf, of,
    input  in_ready
  );

  modport slave (
    input  in_valid, alu_fun, a, b, out, zf, sf, of,
    output in_ready
  );
endinterface

// File: rtl/alu_ref_model.sv
// Combinational Y86-64 OPq reference: expected result and condition codes.
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [1:0]       alu_fun,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] t,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  always_comb begin
    t  = '0;
    of = 1'b0;
    case (alu_fun)
      ALU_ADD: begin
        t  = a + b;
        of = (a[WIDTH-1] == b[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
      end
      // Y86 subq computes valB - valA
      ALU_SUB: begin
        t  = b - a;
        of = (a[WIDTH-1] != b[WIDTH-1]) && (t[WIDTH-1] != b[WIDTH-1]);
      end
      ALU_AND: t = a & b;
      ALU_XOR: t = a ^ b;
    endcase
    zf = (t == '0);
    sf = t[WIDTH-1];
  end

endmodule

// File: rtl/alu_response_checker.sv
// Accepts ALU result vectors, compares them against the reference model one cycle later,
// and keeps saturating pass/fail counts plus a snapshot of the first failing vector.
module alu_response_checker
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_vectors,
  alu_response_checker_if.slave vec,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     pass_cnt,
  output logic [CNT_W-1:0]     fail_cnt,
  output logic [CNT_W-1:0]     first_fail_idx,
  output logic [WIDTH-1:0]     first_fail_exp,
  output logic [WIDTH-1:0]     first_fail_got
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state, state_next;
  logic [CNT_W-1:0] num_reg, acc_cnt, cmp_idx;
  logic             cmp_valid, first_seen;
  logic [1:0]       cmp_fun;
  logic [WIDTH-1:0] cmp_a, cmp_b, cmp_out;
  logic             cmp_zf, cmp_sf, cmp_of;
  logic [WIDTH-1:0] exp_t;
  logic             exp_zf, exp_sf, exp_of;
  logic             xfer, last_xfer, start_ok, mismatch;

  alu_ref_model #(.WIDTH(WIDTH)) u_ref (
    .alu_fun (cmp_fun),
    .a       (cmp_a),
    .b       (cmp_b),
    .t       (exp_t),
    .zf      (exp_zf),
    .sf      (exp_sf),
    .of      (exp_of)
  );

  assign xfer      = vec.in_valid && vec.in_ready;
  assign last_xfer = xfer && (acc_cnt == num_reg - ONE);
  assign start_ok  = start && ((state == IDLE) || (state == DONE));
  assign mismatch  = (exp_t != cmp_out) || (exp_zf != cmp_zf) ||
                     (exp_sf != cmp_sf) || (exp_of != cmp_of);

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = (num_vectors == '0) ? DONE : RUN;
      RUN:        if (last_xfer) state_next = DRAIN;
      DRAIN:      state_next = DONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      vec.in_ready   <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      num_reg        <= '0;
      acc_cnt        <= '0;
      cmp_valid      <= 1'b0;
      cmp_idx        <= '0;
      cmp_fun        <= ALU_ADD;
      cmp_a          <= '0;
      cmp_b          <= '0;
      cmp_out        <= '0;
      cmp_zf         <= 1'b0;
      cmp_sf         <= 1'b0;
      cmp_of         <= 1'b0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_seen     <= 1'b0;
      first_fail_idx <= '0;
      first_fail_exp <= '0;
      first_fail_got <= '0;
    end else begin
      state        <= state_next;
      vec.in_ready <= (state_next == RUN);
      busy         <= (state_next == RUN) || (state_next == DRAIN);
      cmp_valid    <= xfer;
      if (xfer) begin
        cmp_idx <= acc_cnt;
        cmp_fun <= vec.alu_fun;
        cmp_a   <= vec.a;
        cmp_b   <= vec.b;
        cmp_out <= vec.out;
        cmp_zf  <= vec.zf;
        cmp_sf  <= vec.sf;
        cmp_of  <= vec.of;
        acc_cnt <= acc_cnt + ONE;
      end
      if (start_ok) begin
        num_reg        <= num_vectors;
        acc_cnt        <= '0;
        pass_cnt       <= '0;
        fail_cnt       <= '0;
        first_seen     <= 1'b0;
        first_fail_idx <= '0;
        first_fail_exp <= '0;
        first_fail_got <= '0;
        done           <= 1'b0;
        pass           <= 1'b0;
      end else begin
        if (cmp_valid) begin
          if (mismatch) begin
            if (fail_cnt != '1) fail_cnt <= fail_cnt + ONE;
            if (!first_seen) begin
              first_seen     <= 1'b1;
              first_fail_idx <= cmp_idx;
              first_fail_exp <= exp_t;
              first_fail_got <= cmp_out;
            end
          end else if (pass_cnt != '1) begin
            pass_cnt <= pass_cnt + ONE;
          end
        end
        // Counters settle on entry to DONE; the verdict is published one edge later.
        if ((state == DONE) && !done) begin
          done <= 1'b1;
          pass <= (fail_cnt == '0);
        end
      end
    end
  end

endmodule

// File: doc/alu_response_checker.md
# alu_response_checker

Self-checking response end of the ALU verification path: it receives operand/result/condition-code vectors produced by the ALU under test through a valid/ready handshake. It recomputes the expected Y86-64 OPq result and CC flags, then counts passes and failures. It latches the first failing vector for debug. It sits beside the ALU in the processor's built-in self-test wrapper, downstream of the stimulus sequencer.

## Interface
- WIDTH, 64, operand/result width
- CNT_W, 16, width of vector counters and index
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a run, samples num_vectors
- num_vectors  in  CNT_W  vectors expected in this run (0 allowed)
- in_valid  in  1  vector present
- in_ready  out  1  checker accepts vector this cycle
- alu_fun  in  2  Y86 ifun: 0 ADD, 1 SUB, 2 AND, 3 XOR
- a, b  in  WIDTH  signed operands (valA, valB)
- out  in  WIDTH  ALU result under test
- zf, sf, of  in  1  CC flags under test
- busy  out  1  run in progress
- done  out  1  run complete, held until next start
- pass  out  1  done and fail_cnt==0
- pass_cnt, fail_cnt  out  CNT_W  saturating counts
- first_fail_idx  out  CNT_W  index (0-based) of first failing vector
- first_fail_exp, first_fail_got  out  WIDTH  expected/actual result of first failure

## Operation
- FSM states IDLE, RUN, DRAIN, DONE. Reset → IDLE.
- IDLE/DONE: start → RUN; clears counters and first_fail_* and sets accept count to 0. If num_vectors==0, start → DONE directly with pass=1.
- RUN: in_ready=1 while accepted<num_vectors. Transfer = in_valid&&in_ready. On a transfer, capture the vector into the compare stage and increment the accept count. The transfer of vector num_vectors-1 → DRAIN.
- DRAIN: in_ready=0; last compare completes → DONE.
- start in RUN/DRAIN is ignored.
- Expected result: ADD a+b; SUB b-a; AND a&b; XOR a^b. Arithmetic is modulo 2^WIDTH.
- Expected flags: zf=(t==0), sf=t[WIDTH-1].
  - ADD: of = (a[msb]==b[msb]) && (t[msb]!=a[msb]).
  - SUB: of = (a[msb]!=b[msb]) && (t[msb]!=b[msb]).
  - AND/XOR: of=0.
- A vector fails if the result or any flag mismatches. On fail: fail_cnt++. On the first fail of a run, latch idx/exp/got. Otherwise pass_cnt++.
- pass_cnt and fail_cnt saturate at 2^CNT_W-1 and do not wrap.
- Vectors offered while in_ready=0 are not consumed.

## Timing
- Reset values: in_ready=0, busy=0, done=0, pass=0, all counts and first_fail_* = 0.
- Reset asserted mid-run aborts immediately; all state returns to reset values.
- Compare latency is one cycle: a vector transferred at edge N updates the counters at edge N+1.
- in_ready and busy are registered. busy=1 in RUN and DRAIN.
- done/pass rise on the edge after the last counter update: DRAIN lasts exactly one cycle.
- Back-to-back transfers sustain one vector per cycle.

## Structure
- Shared package alu_pkg holds the ALU_ADD/SUB/AND/XOR ifun constants and the FSM state enum, so they are shared with the ALU and the stimulus sequencer.
- One sub-module: alu_ref_model (combinational: alu_fun, a, b → expected t, zf, sf, of). It is reusable by other checkers.

## Test plan
- AND sweep: 100 vectors with A counting down from all-ones-1 and B from all-ones-1, correct out → pass_cnt=100, fail_cnt=0, pass=1.
- ADD overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1, out=0x8000_0000_0000_0000, of=1, sf=1, zf=0 → pass. The same vector with of=0 → fail_cnt=1, first_fail_idx=0.
- SUB zero: a=b=5, out=0, zf=1 → pass. Run of 4 vectors where vector 2 has out=1 → first_fail_idx=2, exp=0, got=1, pass=0.
- Handshake: in_valid toggled randomly; num_vectors=10 → exactly 10 transfers, in_ready=0 afterward, done one cycle after DRAIN, extra valid vectors ignored.
- num_vectors=0 → done next cycle, pass=1, in_ready never high. start during RUN → no effect.
- Reset mid-run after 3 transfers → all outputs zero. A new start with 2 vectors → pass_cnt=2.
